// File: rtl/id_scan_arb.sv
// Two-requester identifier scanner: round-robin grant locked per token, letters+digits+ classifier.
// Result is registered 1 cycle after the delimiter is accepted; no output backpressure, input held off via in_ready.
module id_scan_arb #(
  parameter int LEN_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       in_valid,
  input  logic [7:0]       in_data0,
  input  logic [7:0]       in_data1,
  output logic [1:0]       in_ready,
  output logic             tok_valid,
  output logic             tok_is_id,
  output logic             tok_src,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] id_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALPHA = 2'd1,
    DIGIT = 2'd2,
    BAD   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tok_valid_q, tok_valid_d;
  logic             tok_is_id_q, tok_is_id_d;
  logic             tok_src_q, tok_src_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic [CNT_W-1:0] id_count_q, id_count_d;

  logic             cand_vld;
  logic             cand;
  logic             sel_src;
  logic [7:0]       sel_dat;
  logic             accept;
  logic             is_letter;
  logic             is_digit;
  logic [LEN_W-1:0] len_inc;

  // Candidate favours the rr pointer, falls back to the other requester.
  always_comb begin
    cand_vld = 1'b0;
    cand     = rr_q;
    if (in_valid[rr_q]) begin
      cand_vld = 1'b1;
      cand     = rr_q;
    end else if (in_valid[~rr_q]) begin
      cand_vld = 1'b1;
      cand     = ~rr_q;
    end
  end

  always_comb begin
    in_ready = 2'b00;
    if (state_q == IDLE) begin
      if (cand_vld) in_ready[cand] = 1'b1;
    end else begin
      in_ready[owner_q] = 1'b1;
    end
  end

  assign sel_src   = (state_q == IDLE) ? cand : owner_q;
  assign sel_dat   = sel_src ? in_data1 : in_data0;
  assign accept    = in_valid[sel_src] & in_ready[sel_src];
  assign is_letter = ((sel_dat >= 8'h41) && (sel_dat <= 8'h5A)) ||
                     ((sel_dat >= 8'h61) && (sel_dat <= 8'h7A));
  assign is_digit  = (sel_dat >= 8'h30) && (sel_dat <= 8'h39);
  assign len_inc   = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    len_d       = len_q;
    tok_valid_d = 1'b0;
    tok_is_id_d = tok_is_id_q;
    tok_src_d   = tok_src_q;
    tok_len_d   = tok_len_q;
    id_count_d  = id_count_q;

    if (accept) begin
      if (state_q == IDLE) begin
        owner_d = cand;
        if (is_letter) begin
          state_d = ALPHA;
          len_d   = {{(LEN_W-1){1'b0}}, 1'b1};
        end else if (is_digit) begin
          state_d = BAD;
          len_d   = {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          rr_d = ~rr_q;
        end
      end else if (is_letter || is_digit) begin
        len_d = len_inc;
        case (state_q)
          ALPHA:   state_d = is_digit  ? DIGIT : ALPHA;
          DIGIT:   state_d = is_letter ? BAD   : DIGIT;
          default: state_d = BAD;
        endcase
      end else begin
        // Delimiter closes the token; result appears on the following cycle.
        tok_valid_d = 1'b1;
        tok_is_id_d = (state_q == DIGIT);
        tok_src_d   = owner_q;
        tok_len_d   = len_q;
        if (state_q == DIGIT) id_count_d = id_count_q + 1'b1;
        state_d = IDLE;
        len_d   = '0;
        rr_d    = ~owner_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      len_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_is_id_q <= 1'b0;
      tok_src_q   <= 1'b0;
      tok_len_q   <= '0;
      id_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      tok_valid_q <= tok_valid_d;
      tok_is_id_q <= tok_is_id_d;
      tok_src_q   <= tok_src_d;
      tok_len_q   <= tok_len_d;
      id_count_q  <= id_count_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_is_id = tok_is_id_q;
  assign tok_src   = tok_src_q;
  assign tok_len   = tok_len_q;
  assign id_count  = id_count_q;

endmodule

// File: tb/tb_id_scan_arb.sv
// Directed bench for id_scan_arb: inputs change 1ns after the rising edge, outputs are checked between edges.
module tb_id_scan_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [7:0]  in_data0 = 8'h00;
  logic [7:0]  in_data1 = 8'h00;
  logic [1:0]  in_ready;
  logic        tok_valid;
  logic        tok_is_id;
  logic        tok_src;
  logic [5:0]  tok_len;
  logic [15:0] id_count;

  int checks = 0;
  int failures = 0;

  id_scan_arb #(.LEN_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
    .in_ready(in_ready), .tok_valid(tok_valid), .tok_is_id(tok_is_id), .tok_src(tok_src),
    .tok_len(tok_len), .id_count(id_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one char from a single requester, wait (bounded) for its grant, consume on the next edge.
  task automatic push(input int src, input logic [7:0] ch);
    int n;
    n = 0;
    in_valid = 2'b00;
    in_valid[src] = 1'b1;
    if (src == 0) in_data0 = ch; else in_data1 = ch;
    #1;
    while (!in_ready[src] && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[src]) begin
      checks++;
      failures++;
      $error("FAIL push_timeout observed=%0h expected=%0h", in_ready, 2'b1 << src);
    end
    @(posedge clk); #1;
    in_valid = 2'b00;
  endtask

  task automatic push_str(input int src, input string s);
    for (int i = 0; i < s.len(); i++) push(src, s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tok_valid", tok_valid, 0);
    check("rst_tok_is_id", tok_is_id, 0);
    check("rst_tok_src", tok_src, 0);
    check("rst_tok_len", tok_len, 0);
    check("rst_id_count", id_count, 0);
    check("rst_in_ready", in_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: "Ab73;" is an identifier of length 4
    push_str(0, "Ab73");
    check("t1_no_early_pulse", tok_valid, 0);
    push(0, ";");
    check("t1_valid", tok_valid, 1);
    check("t1_is_id", tok_is_id, 1);
    check("t1_src", tok_src, 0);
    check("t1_len", tok_len, 4);
    check("t1_id_count", id_count, 1);
    @(posedge clk); #1;
    check("t1_pulse_one_cycle", tok_valid, 0);
    check("t1_len_hold", tok_len, 4);
    check("t1_is_id_hold", tok_is_id, 1);

    // 2: letters only, then letter-digit-letter
    push_str(0, "ABC ");
    check("t2a_valid", tok_valid, 1);
    check("t2a_is_id", tok_is_id, 0);
    check("t2a_len", tok_len, 3);
    push_str(0, "A1B,");
    check("t2b_valid", tok_valid, 1);
    check("t2b_is_id", tok_is_id, 0);
    check("t2b_len", tok_len, 3);
    check("t2_id_count", id_count, 1);

    // 3: leading digit from requester 1; lone delimiter in IDLE toggles rr
    push_str(1, "9X;");
    check("t3_valid", tok_valid, 1);
    check("t3_is_id", tok_is_id, 0);
    check("t3_src", tok_src, 1);
    check("t3_len", tok_len, 2);
    push(0, ";");
    check("t3_delim_no_pulse", tok_valid, 0);
    in_valid = 2'b11;
    in_data0 = "a";
    in_data1 = "b";
    #1;
    check("t3_rr_toggled", in_ready, 2'b10);
    in_valid = 2'b00;
    check("t3_id_count", id_count, 1);

    // 4: both requesters contend after reset; grant locks to requester 0
    do_reset();
    in_valid = 2'b11;
    in_data0 = "X";
    in_data1 = "Y";
    #1;
    check("t4_ready_start", in_ready, 2'b01);
    @(posedge clk); #1;
    in_data0 = "1";
    #1;
    check("t4_ready_locked0", in_ready, 2'b01);
    @(posedge clk); #1;
    in_data0 = ";";
    @(posedge clk); #1;
    check("t4a_valid", tok_valid, 1);
    check("t4a_src", tok_src, 0);
    check("t4a_is_id", tok_is_id, 1);
    check("t4_ready_switch", in_ready, 2'b10);
    @(posedge clk); #1;
    in_data1 = "2";
    #1;
    check("t4_ready_locked1", in_ready, 2'b10);
    @(posedge clk); #1;
    in_data1 = ";";
    @(posedge clk); #1;
    in_valid = 2'b00;
    check("t4b_valid", tok_valid, 1);
    check("t4b_src", tok_src, 1);
    check("t4b_is_id", tok_is_id, 1);
    check("t4b_len", tok_len, 2);
    check("t4_id_count", id_count, 2);

    // 5: 70 letters saturate the 6-bit length
    for (int i = 0; i < 70; i++) push(0, "q");
    push(0, " ");
    check("t5_valid", tok_valid, 1);
    check("t5_len_sat", tok_len, 63);
    check("t5_is_id", tok_is_id, 0);

    // 6: reset mid-token discards it
    push_str(0, "AB1");
    #2;
    rst_n = 1'b0;
    in_valid = 2'b11;
    in_data0 = "c";
    in_data1 = "d";
    #1;
    check("t6_no_pulse", tok_valid, 0);
    check("t6_id_count", id_count, 0);
    check("t6_tok_len", tok_len, 0);
    check("t6_ready_rr0", in_ready, 2'b01);
    in_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_no_pulse", tok_valid, 0);
    push_str(0, "Q5;");
    check("t6_valid", tok_valid, 1);
    check("t6_is_id", tok_is_id, 1);
    check("t6_src", tok_src, 0);
    check("t6_len", tok_len, 2);
    check("t6_id_count_after", id_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
